// File: rtl/cam_dma_writer.sv
// Multi-camera frame writer: packs 32-bit pixel words into 128-bit beats per channel and bursts them into per-channel host ring buffers.
// Define CAM_DMA_STATS_EN to build the drop/beat statistics counters; otherwise the stat ports read 0.
module cam_dma_writer #(
  parameter int N_CAM     = 2,
  parameter int BURST     = 8,
  parameter int FIFO_LOG2 = 6,
  parameter int RING_LOG2 = 12,
  parameter int ADDR_W    = 22
) (
  input  logic                  c,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CAM-1:0]      in_valid,
  input  logic [32*N_CAM-1:0]   in_data,
  input  logic [N_CAM-1:0]      in_eof,
  output logic                  txs_write,
  output logic [127:0]          txs_writedata,
  output logic [5:0]            txs_burstcount,
  output logic [ADDR_W-1:0]     txs_address,
  input  logic                  txs_waitrequest,
  output logic [N_CAM-1:0]      irq,
  input  logic [N_CAM-1:0]      irq_clr,
  output logic [N_CAM-1:0]      overflow,
  output logic [16*N_CAM-1:0]   stat_drops,
  output logic [32*N_CAM-1:0]   stat_beats
);

  localparam int CW    = (N_CAM > 1) ? $clog2(N_CAM) : 1;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int RING  = 1 << RING_LOG2;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_DONE = 2'd2} state_t;

  logic [1:0]           lane_r    [N_CAM];
  logic [95:0]          pack_r    [N_CAM];
  logic [127:0]         beat_s    [N_CAM];
  logic [N_CAM-1:0]     push_s, wr_en_s, drop_s, pop_s, pop_eof_s;

  logic [128:0]         mem_r     [N_CAM][DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_r  [N_CAM];
  logic [FIFO_LOG2-1:0] rd_ptr_r  [N_CAM];
  logic [FIFO_LOG2:0]   cnt_r     [N_CAM];
  logic [FIFO_LOG2:0]   eof_cnt_r [N_CAM];
  logic [N_CAM-1:0]     elig_r, overflow_r, irq_r;
  logic [RING_LOG2-1:0] wptr_r    [N_CAM];

  state_t               state_r, state_s;
  logic [CW-1:0]        gnt_r, sel_s;
  logic                 found_s, accept_s, burst_eof_r, txs_write_r;
  logic [5:0]           len_s, left_r, burst_len_r, txs_burstcount_r;
  logic [ADDR_W-1:0]    addr_s, txs_address_r;
  logic [127:0]         txs_writedata_r;
  logic [FIFO_LOG2-1:0] ridx_s, nxt_s;
  int                   idx_i, len_i, rem_i, cnt_i;
  logic                 eof_hit_s;

  // Packer lane insertion and push/drop decode per channel
  always_comb begin
    for (int k = 0; k < N_CAM; k++) begin
      push_s[k] = in_valid[k] && ((lane_r[k] == 2'd3) || in_eof[k]);
      beat_s[k] = {32'h0000_0000, pack_r[k]};
      beat_s[k][{lane_r[k], 5'd0} +: 32] = in_data[32*k +: 32];
      wr_en_s[k]   = push_s[k] && (cnt_r[k] != (FIFO_LOG2+1)'(DEPTH));
      drop_s[k]    = push_s[k] && (cnt_r[k] == (FIFO_LOG2+1)'(DEPTH));
      pop_s[k]     = accept_s && (gnt_r == CW'(k));
      pop_eof_s[k] = pop_s[k] && mem_r[k][rd_ptr_r[k]][128];
    end
  end

  // Packer state: lane index and the partially filled beat
  always_ff @(posedge c) begin
    if (rst) begin
      for (int k = 0; k < N_CAM; k++) begin
        lane_r[k] <= 2'd0;
        pack_r[k] <= 96'h0;
      end
    end else begin
      for (int k = 0; k < N_CAM; k++) begin
        if (in_valid[k]) begin
          // eof resets the packer even when the FIFO drops the beat
          lane_r[k] <= push_s[k] ? 2'd0 : lane_r[k] + 2'd1;
          pack_r[k] <= push_s[k] ? 96'h0 : beat_s[k][95:0];
        end
      end
    end
  end

  // FIFO storage (no reset needed, validity is tracked by the pointers)
  always_ff @(posedge c) begin
    for (int k = 0; k < N_CAM; k++) begin
      if (wr_en_s[k]) begin
        mem_r[k][wr_ptr_r[k]] <= {in_eof[k], beat_s[k]};
      end
    end
  end

  // FIFO pointers, occupancy, eof tracking, eligibility and overflow flags
  always_ff @(posedge c) begin
    if (rst) begin
      for (int k = 0; k < N_CAM; k++) begin
        wr_ptr_r[k]  <= '0;
        rd_ptr_r[k]  <= '0;
        cnt_r[k]     <= '0;
        eof_cnt_r[k] <= '0;
      end
      elig_r     <= '0;
      overflow_r <= '0;
    end else begin
      for (int k = 0; k < N_CAM; k++) begin
        wr_ptr_r[k]  <= wr_ptr_r[k] + FIFO_LOG2'(wr_en_s[k]);
        rd_ptr_r[k]  <= rd_ptr_r[k] + FIFO_LOG2'(pop_s[k]);
        cnt_r[k]     <= cnt_r[k] + (FIFO_LOG2+1)'(wr_en_s[k]) - (FIFO_LOG2+1)'(pop_s[k]);
        eof_cnt_r[k] <= eof_cnt_r[k] + (FIFO_LOG2+1)'(wr_en_s[k] && in_eof[k])
                        - (FIFO_LOG2+1)'(pop_eof_s[k]);
        elig_r[k]    <= (cnt_r[k] >= (FIFO_LOG2+1)'(BURST)) || (eof_cnt_r[k] != '0);
      end
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Round-robin pick after the last grant, and burst length for the pick
  always_comb begin
    found_s   = 1'b0;
    sel_s     = gnt_r;
    idx_i     = 0;
    eof_hit_s = 1'b0;
    ridx_s    = '0;
    for (int i = 1; i <= N_CAM; i++) begin
      idx_i = (int'(gnt_r) + i) % N_CAM;
      if (!found_s && elig_r[idx_i]) begin
        found_s = 1'b1;
        sel_s   = CW'(idx_i);
      end else begin
        found_s = found_s;
      end
    end
    cnt_i = int'(cnt_r[sel_s]);
    rem_i = RING - int'(wptr_r[sel_s]);
    len_i = BURST;
    if (cnt_i < len_i) len_i = cnt_i; else len_i = len_i;
    if (rem_i < len_i) len_i = rem_i; else len_i = len_i;
    // A flush burst ends on the first eof beat
    for (int i = 0; i < BURST; i++) begin
      ridx_s = rd_ptr_r[sel_s] + FIFO_LOG2'(i);
      if (!eof_hit_s && (i < cnt_i) && mem_r[sel_s][ridx_s][128]) begin
        eof_hit_s = 1'b1;
        if (i + 1 < len_i) len_i = i + 1; else len_i = len_i;
      end else begin
        eof_hit_s = eof_hit_s;
      end
    end
    len_s    = 6'(len_i);
    addr_s   = ADDR_W'({sel_s, wptr_r[sel_s], 4'h0});
    nxt_s    = rd_ptr_r[gnt_r] + FIFO_LOG2'(1);
    accept_s = (state_r == ST_BURST) && !txs_waitrequest;
  end

  // Arbiter next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (en && found_s) state_s = ST_BURST; else state_s = ST_IDLE;
      ST_BURST: if (accept_s && (left_r == 6'd1)) state_s = ST_DONE; else state_s = ST_BURST;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Arbiter state register and registered TXS outputs
  always_ff @(posedge c) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      gnt_r            <= CW'(N_CAM - 1);
      left_r           <= 6'd0;
      burst_len_r      <= 6'd0;
      burst_eof_r      <= 1'b0;
      txs_write_r      <= 1'b0;
      txs_writedata_r  <= 128'h0;
      txs_burstcount_r <= 6'd0;
      txs_address_r    <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (state_s == ST_BURST) begin
            gnt_r            <= sel_s;
            left_r           <= len_s;
            burst_len_r      <= len_s;
            burst_eof_r      <= 1'b0;
            txs_write_r      <= 1'b1;
            txs_burstcount_r <= len_s;
            txs_address_r    <= addr_s;
            txs_writedata_r  <= mem_r[sel_s][rd_ptr_r[sel_s]][127:0];
          end
        end
        ST_BURST: begin
          if (accept_s) begin
            left_r      <= left_r - 6'd1;
            burst_eof_r <= burst_eof_r | mem_r[gnt_r][rd_ptr_r[gnt_r]][128];
            if (left_r == 6'd1) begin
              txs_write_r <= 1'b0;
            end else begin
              txs_writedata_r <= mem_r[gnt_r][nxt_s][127:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Ring write pointers and sticky frame-done interrupts
  always_ff @(posedge c) begin
    if (rst) begin
      for (int k = 0; k < N_CAM; k++) wptr_r[k] <= '0;
      irq_r <= '0;
    end else begin
      if (state_r == ST_DONE) begin
        wptr_r[gnt_r] <= wptr_r[gnt_r] + RING_LOG2'(burst_len_r);
      end
      for (int k = 0; k < N_CAM; k++) begin
        if ((state_r == ST_DONE) && burst_eof_r && (gnt_r == CW'(k))) irq_r[k] <= 1'b1;
        else if (irq_clr[k]) irq_r[k] <= 1'b0;
      end
    end
  end

  assign txs_write      = txs_write_r;
  assign txs_writedata  = txs_writedata_r;
  assign txs_burstcount = txs_burstcount_r;
  assign txs_address    = txs_address_r;
  assign irq            = irq_r;
  assign overflow       = overflow_r;

`ifdef CAM_DMA_STATS_EN
  logic [15:0] drops_r [N_CAM];
  logic [31:0] beats_r [N_CAM];

  // Saturating drop counters and wrapping beat counters
  always_ff @(posedge c) begin
    if (rst) begin
      for (int k = 0; k < N_CAM; k++) begin
        drops_r[k] <= 16'h0;
        beats_r[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < N_CAM; k++) begin
        if (drop_s[k] && (drops_r[k] != 16'hFFFF)) drops_r[k] <= drops_r[k] + 16'd1;
        if (pop_s[k]) beats_r[k] <= beats_r[k] + 32'd1;
      end
    end
  end

  // Flatten counters onto the stat ports
  always_comb begin
    stat_drops = '0;
    stat_beats = '0;
    for (int k = 0; k < N_CAM; k++) begin
      stat_drops[16*k +: 16] = drops_r[k];
      stat_beats[32*k +: 32] = beats_r[k];
    end
  end
`else
  assign stat_drops = '0;
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_cam_dma_writer.sv
// Scoreboard bench for cam_dma_writer: expected beats are queued before stimulus, a negedge monitor checks each TXS beat.
module tb_cam_dma_writer;

  logic         clk = 1'b0;
  logic         rst, en, txs_waitrequest;
  logic [1:0]   in_valid, in_eof, irq_clr, irq, overflow;
  logic [63:0]  in_data;
  logic         txs_write;
  logic [127:0] txs_writedata;
  logic [5:0]   txs_burstcount;
  logic [21:0]  txs_address;
  logic [31:0]  stat_drops;
  logic [63:0]  stat_beats;

  typedef struct packed {
    logic [21:0]  addr;
    logic [5:0]   bc;
    logic [127:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;

  always #4 clk = ~clk;

  cam_dma_writer #(.N_CAM(2), .BURST(8), .FIFO_LOG2(6), .RING_LOG2(5), .ADDR_W(22)) dut (
    .c(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
    .txs_write(txs_write), .txs_writedata(txs_writedata),
    .txs_burstcount(txs_burstcount), .txs_address(txs_address),
    .txs_waitrequest(txs_waitrequest),
    .irq(irq), .irq_clr(irq_clr), .overflow(overflow),
    .stat_drops(stat_drops), .stat_beats(stat_beats)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wv(input int tag, input int ch, input int n);
    return {8'(tag), 8'(ch), 16'(n)};
  endfunction

  // Beat j of a frame of nw words: lanes low to high, zero past the end
  function automatic logic [127:0] bv(input int tag, input int ch, input int j, input int nw);
    logic [127:0] d;
    d = 128'h0;
    for (int l = 0; l < 4; l++)
      if (4*j + l < nw) d[32*l +: 32] = wv(tag, ch, 4*j + l);
    return d;
  endfunction

  task automatic expect_burst(input int tag, input int ch, input int first, input int bc,
                              input logic [21:0] addr, input int nw);
    exp_t e;
    for (int j = first; j < first + bc; j++) begin
      e.addr = addr;
      e.bc   = 6'(bc);
      e.data = bv(tag, ch, j, nw);
      sb_q.push_back(e);
    end
  endtask

  task automatic send(input int tag, input logic [1:0] mask, input int n, input logic eof);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = mask;
      in_data  = {wv(tag, 1, i), wv(tag, 0, i)};
      in_eof   = (eof && (i == n - 1)) ? mask : 2'b00;
    end
    @(posedge clk); #1;
    in_valid = 2'b00;
    in_eof   = 2'b00;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while (((sb_q.size() != 0) || txs_write) && (n < max)) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, 128'(sb_q.size()), 128'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; in_valid = 2'b00; in_eof = 2'b00; in_data = 64'h0;
    irq_clr = 2'b00; txs_waitrequest = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_irq();
    @(posedge clk); #1 irq_clr = 2'b01;
    @(posedge clk); #1 irq_clr = 2'b00;
  endtask

  // Monitor: every presented beat must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && txs_write) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=addr %h data %h required=no beat", txs_address, txs_writedata);
      end else begin
        chk("txs_address", 128'(txs_address), 128'(sb_q[0].addr));
        chk("txs_burstcount", 128'(txs_burstcount), 128'(sb_q[0].bc));
        chk("txs_writedata", txs_writedata, sb_q[0].data);
        if (!txs_waitrequest) begin
          void'(sb_q.pop_front());
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    int n;
    do_reset();
    chk("rst_write", 128'(txs_write), 128'd0);
    chk("rst_writedata", txs_writedata, 128'h0);
    chk("rst_burstcount", 128'(txs_burstcount), 128'd0);
    chk("rst_address", 128'(txs_address), 128'd0);
    chk("rst_irq", 128'(irq), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_stat_drops", 128'(stat_drops), 128'd0);
    chk("rst_stat_beats", 128'(stat_beats), 128'd0);

    // 32 words on ch0, then 32 more landing at wptr0 = 8
    en = 1'b1;
    expect_burst(1, 0, 0, 8, 22'h000, 32);
    send(1, 2'b01, 32, 1'b0);
    wait_drain("drain_t1", 100);
    chk("t1_irq", 128'(irq), 128'd0);
    expect_burst(11, 0, 0, 8, 22'h080, 32);
    send(11, 2'b01, 32, 1'b0);
    wait_drain("drain_t1b", 100);
`ifdef CAM_DMA_STATS_EN
    chk("t1_stat_beats", 128'(stat_beats[31:0]), 128'd16);
`endif

    // Both channels eligible with last grant = 1 after reset
    do_reset();
    expect_burst(2, 0, 0, 8, 22'h000, 32);
    expect_burst(2, 1, 0, 8, 22'h200, 32);
    send(2, 2'b11, 32, 1'b0);
    en = 1'b1;
    wait_drain("drain_t2", 100);

    // 10-word frame with eof: 3-beat flush burst and irq
    do_reset();
    en = 1'b1;
    expect_burst(3, 0, 0, 3, 22'h000, 10);
    send(3, 2'b01, 10, 1'b1);
    wait_drain("drain_t3", 100);
    chk("t3_irq_set", 128'(irq), 128'd1);
    clear_irq();
    chk("t3_irq_clr", 128'(irq), 128'd0);

    // Advance wptr0 to 29, then a queued 8-beat frame splits at the ring end
    do_reset();
    en = 1'b1;
    expect_burst(4, 0, 0, 8, 22'h000, 116);
    expect_burst(4, 0, 8, 8, 22'h080, 116);
    expect_burst(4, 0, 16, 8, 22'h100, 116);
    expect_burst(4, 0, 24, 5, 22'h180, 116);
    send(4, 2'b01, 116, 1'b1);
    wait_drain("drain_t4a", 300);
    chk("t4_irq_a", 128'(irq), 128'd1);
    clear_irq();
    chk("t4_irq_clr", 128'(irq), 128'd0);
    en = 1'b0;
    expect_burst(5, 0, 0, 3, 22'h1D0, 32);
    expect_burst(5, 0, 3, 5, 22'h000, 32);
    send(5, 2'b01, 32, 1'b1);
    en = 1'b1;
    wait_drain("drain_t4b", 100);
    chk("t4_irq_b", 128'(irq), 128'd1);

    // Five-cycle stall on beat 2
    do_reset();
    expect_burst(6, 0, 0, 8, 22'h000, 32);
    send(6, 2'b01, 32, 1'b0);
    acc_cnt = 0;
    en = 1'b1;
    n = 0;
    while ((acc_cnt < 2) && (n < 50)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reach_beat2", 128'(acc_cnt), 128'd2);
    txs_waitrequest = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_stalled", 128'(acc_cnt), 128'd2);
    txs_waitrequest = 1'b0;
    wait_drain("drain_t5", 100);
    chk("t5_beats", 128'(acc_cnt), 128'd8);
`ifdef CAM_DMA_STATS_EN
    chk("t5_stat_beats", 128'(stat_beats[31:0]), 128'd8);
`endif

    // Fill the FIFO with en=0, 8 extra words drop two beats
    do_reset();
    send(7, 2'b01, 264, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_overflow", 128'(overflow), 128'd1);
`ifdef CAM_DMA_STATS_EN
    chk("t6_stat_drops", 128'(stat_drops[15:0]), 128'd2);
`else
    chk("t6_stat_drops", 128'(stat_drops[15:0]), 128'd0);
`endif
    for (int b = 0; b < 8; b++) expect_burst(7, 0, 8*b, 8, 22'((b % 4) * 128), 264);
    en = 1'b1;
    wait_drain("drain_t6", 400);
    chk("t6_overflow_sticky", 128'(overflow), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
